restador_seq: RTL and testbench
===============================

# restador_seq

Multi-cycle sequencer that divides two unsigned N-bit operands by repeated subtraction, using one shared subtractor datapath (two's-complement add of the inverted divisor). It sits above the team's restador datapath in problem1. It accepts a single start pulse, iterates one subtraction per clock, and returns a registered quotient and remainder with a one-cycle done pulse.

## Interface
- N, default 4, operand/result width in bits (N >= 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- a  input  N  dividend, unsigned; captured on accepted start
- b  input  N  divisor, unsigned; captured on accepted start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; results valid
- div_by_zero  output  1  set with done when captured b == 0; held until next accepted start
- quotient  output  N  registered quotient; held until next DONE
- remainder  output  N  registered remainder; held until next DONE

## Operation
- States: IDLE, SUB, DONE. Internal registers: rem (N), q (N), div (N).
- Subtractor: diff = {1'b0,rem} + {1'b0,~div} + 1, N+1 bits; carry = diff[N]; carry=1 means rem >= div, no borrow.
- IDLE: start=1 -> capture div<=b; clear div_by_zero.
  - b != 0: rem<=a, q<=0, go SUB.
  - b == 0: quotient<={N{1'b1}}, remainder<=a, div_by_zero<=1, go DONE.
  - start=0: stay.
- SUB, each cycle:
  - carry=1: rem<=diff[N-1:0], q<=q+1, stay.
  - carry=0: quotient<=q, remainder<=rem, go DONE.
- DONE: done=1 for this cycle only; next edge -> IDLE unconditionally.
- start outside IDLE (SUB or DONE) ignored; no queuing. a/b changes after capture have no effect.
- q cannot overflow: div >= 1 bounds quotient to 2^N-1.
- Reset (any state, any time): state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0; rem/q/div = 0. Operation in flight is discarded.

## Timing
- Edge 0 = edge sampling start in IDLE. Q = a/b.
- b != 0: SUB occupies Q+1 cycles; DONE entered at edge Q+1; done high for cycle after edge Q+1; IDLE after edge Q+2.
- b == 0: DONE entered at edge 0; done high for the cycle after edge 0.
- busy rises after edge 0, falls after DONE->IDLE edge; done and busy are both high in DONE.
- Back-to-back: start held high through DONE is accepted on the first IDLE cycle (edge Q+3 earliest).
- Worst case latency (a=2^N-1, b=1): done after edge 2^N.
- All outputs registered, glitch-free; no combinational path from inputs to outputs.

## Test plan
- Reset: rst_n low mid-clock, no clk edge -> busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 immediately.
- a=13, b=4, one-cycle start -> done pulses once after edge 4; quotient=3, remainder=1, div_by_zero=0; busy high after edges 0-4.
- a=3, b=5 -> done after edge 1; quotient=0, remainder=3.
- a=15, b=1 -> done after edge 16; quotient=15, remainder=0. Also a=7, b=0 -> done after edge 0; div_by_zero=1, quotient=4'hF, remainder=7.
- a=12, b=3, then start=1 with a=1, b=1 on edges 1-3 -> second request ignored; quotient=4, remainder=0 after edge 5; inputs changed after capture do not alter results.
- a=15, b=2, rst_n pulsed low after edge 3 -> immediate IDLE, all outputs 0, no done; next start a=9, b=2 -> quotient=4, remainder=1 after edge 5.

Source files
------------

// File: rtl/restador_seq.sv
// Multi-cycle unsigned divider using repeated subtraction on one shared subtractor.
// A start in IDLE captures the operands. Quotient and remainder are registered and come with a one-cycle done pulse.
module restador_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_busy;
  logic         r_done;
  logic         w_busy_nxt;
  logic         w_done_nxt;
  logic         r_dbz;
  logic [N-1:0] r_rem;
  logic [N-1:0] r_q;
  logic [N-1:0] r_div;
  logic [N-1:0] r_quotient;
  logic [N-1:0] r_remainder;
  logic [N:0]   w_diff;
  logic         w_carry;

  // Shared subtractor: rem - div as an add of the inverted divisor. A carry out means rem >= div.
  assign w_diff  = {1'b0, r_rem} + {1'b0, ~r_div} + {{N{1'b0}}, 1'b1};
  assign w_carry = w_diff[N];

  // State register; busy/done are registered from the next state so outputs never glitch.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // NOTE: a default assignment at the top of always_comb prevents inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_state_nxt = (b == '0) ? S_DONE : S_SUB;
      S_SUB:  if (!w_carry) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // Datapath: capture, iterate and publish the results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem       <= '0;
      r_q         <= '0;
      r_div       <= '0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_div <= b;
            r_dbz <= 1'b0;
            if (b != '0) begin
              r_rem <= a;
              r_q   <= '0;
            end else begin
              r_quotient  <= '1;
              r_remainder <= a;
              r_dbz       <= 1'b1;
            end
          end
        end
        S_SUB: begin
          if (w_carry) begin
            r_rem <= w_diff[N-1:0];
            r_q   <= r_q + {{(N-1){1'b0}}, 1'b1};
          end else begin
            r_quotient  <= r_q;
            r_remainder <= r_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;

endmodule

// File: tb/tb_restador_seq.sv
// Scoreboard bench for restador_seq.
// The driver pushes the result computed with plain / and %. A monitor pops that result and compares it whenever done is high.
module tb_restador_seq;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done, div_by_zero;
  logic [N-1:0] quotient, remainder;

  restador_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned q;
    int unsigned r;
    int unsigned dbz;
    int unsigned due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      check("done_single_cycle", int'(prev_done), 0);
      check("busy_in_done", int'(busy), 1);
      if (sb.size() == 0) begin
        check("spurious_done", int'(done), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", int'(quotient), e.q);
        check("remainder", int'(remainder), e.r);
        check("div_by_zero", int'(div_by_zero), e.dbz);
        check("done_latency", cyc, e.due);
      end
    end
    prev_done = rst_n && done;
  end

  function automatic exp_t model(input int unsigned av, input int unsigned bv, input int unsigned now);
    exp_t e;
    if (bv == 0) begin
      e.q = (1 << N) - 1; e.r = av; e.dbz = 1; e.due = now + 1;
    end else begin
      e.q = av / bv; e.r = av % bv; e.dbz = 0; e.due = now + 1 + av / bv + 1;
    end
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) check("idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_drained();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) check("done_timeout", sb.size(), 0);
  endtask

  // Drive a one-cycle start on an idle DUT and queue the expected result.
  task automatic issue(input int unsigned av, input int unsigned bv);
    wait_idle();
    a = N'(av); b = N'(bv); start = 1'b1;
    sb.push_back(model(av, bv, cyc));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", int'(busy), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_quotient"}, int'(quotient), 0);
    check({tag, "_remainder"}, int'(remainder), 0);
    check({tag, "_dbz"}, int'(div_by_zero), 0);
  endtask

  initial begin
    // Asynchronous reset with no clock edge
    #1;
    check_reset_outputs("rst_initial");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(13, 4); wait_drained();
    issue(3, 5);  wait_drained();
    issue(15, 1); wait_drained();
    issue(7, 0);  wait_drained();
    repeat (2) @(negedge clk);
    check("dbz_held", int'(div_by_zero), 1);
    check("quotient_held", int'(quotient), 15);
    check("remainder_held", int'(remainder), 7);
    issue(6, 3);
    check("dbz_cleared", int'(div_by_zero), 0);
    wait_drained();

    // A second request arrives while busy and must be ignored. The operands change after capture.
    wait_idle();
    a = 4'd12; b = 4'd3; start = 1'b1;
    sb.push_back(model(12, 3, cyc));
    @(negedge clk); a = 4'd1; b = 4'd1;
    @(negedge clk); @(negedge clk);
    start = 1'b0;
    wait_drained();

    // Reset in flight discards the operation
    issue(15, 2);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_inflight");
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(9, 2); wait_drained();

    // Back-to-back requests
    issue(10, 3); issue(5, 5); wait_drained();

    for (int i = 0; i < 40; i++) begin
      issue($urandom_range(0, 15), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drained();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
